// File: rtl/ws2812_pkg.sv
// Shared WS2812 encoder/controller types and nominal timing constants (200 MHz clock).
package ws2812_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_HIGH = 2'd1,
    ENC_LOW  = 2'd2
  } enc_state_t;

  localparam logic [CNT_W-1:0] T0H_NOM  = 8'd80;
  localparam logic [CNT_W-1:0] T1H_NOM  = 8'd160;
  localparam logic [CNT_W-1:0] TBIT_NOM = 8'd249;

  // Reset/latch low time for the controller: 280 us at 5 ns per clock.
  localparam int unsigned CNT_280_US = 56000;

endpackage

// File: rtl/ws2812_bit_enc.sv
// WS2812 single-bit NRZ encoder: long high for '1', short high for '0', then low to the end of the bit.
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter logic OUT_INV = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             bit_rdy_in,
  input  logic             bit_data_in,
  input  logic [CNT_W-1:0] t0h_cnt_in,
  input  logic [CNT_W-1:0] t1h_cnt_in,
  input  logic [CNT_W-1:0] tbit_cnt_in,
  output logic             bit_done_out,
  output logic             busy_out,
  output logic             ovf_out,
  output logic             ws2812_dout
);

  enc_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] th_q, th_nxt;
  logic [CNT_W-1:0] tl_q, tl_nxt;
  logic [CNT_W-1:0] th_calc, tl_calc;
  logic             done_q, done_nxt;
  logic             busy_q, busy_nxt;
  logic             ovf_q, ovf_nxt;
  logic             dout_q, dout_nxt;

  // State, counter and output registers; reset forces the line to its idle level at once.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ENC_IDLE;
      cnt_q   <= '0;
      th_q    <= '0;
      tl_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= OUT_INV;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      th_q    <= th_nxt;
      tl_q    <= tl_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
      ovf_q   <= ovf_nxt;
      dout_q  <= dout_nxt;
    end
  end

  // Next state; outputs are derived from the next state so they line up with the registered state.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    th_nxt    = th_q;
    tl_nxt    = tl_q;
    ovf_nxt   = ovf_q;

    // High time is never zero and the low phase never wraps.
    th_calc = bit_data_in ? t1h_cnt_in : t0h_cnt_in;
    if (th_calc == '0) th_calc = CNT_W'(1);
    tl_calc = (tbit_cnt_in > th_calc) ? CNT_W'(tbit_cnt_in - th_calc) : CNT_W'(1);

    unique case (state_q)
      ENC_IDLE: begin
        if (bit_rdy_in) begin
          state_nxt = ENC_HIGH;
          cnt_nxt   = '0;
          th_nxt    = th_calc;
          tl_nxt    = tl_calc;
        end
      end
      ENC_HIGH: begin
        if (cnt_q == CNT_W'(th_q - CNT_W'(1))) begin
          state_nxt = ENC_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      ENC_LOW: begin
        if (cnt_q == CNT_W'(tl_q - CNT_W'(1))) begin
          state_nxt = ENC_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      default: begin
        state_nxt = ENC_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (bit_rdy_in && (state_q != ENC_IDLE)) ovf_nxt = 1'b1;

    busy_nxt = (state_nxt != ENC_IDLE);
    dout_nxt = (state_nxt == ENC_HIGH) ^ OUT_INV;
    done_nxt = (state_nxt == ENC_LOW) && (cnt_nxt == CNT_W'(tl_nxt - CNT_W'(1)));
  end

  assign bit_done_out = done_q;
  assign busy_out     = busy_q;
  assign ovf_out      = ovf_q;
  assign ws2812_dout  = dout_q;

endmodule

// File: tb/tb_ws2812_bit_enc.sv
// Scoreboard bench for ws2812_bit_enc: stimulus pushes expected pulse widths, a monitor measures the line.
module tb_ws2812_bit_enc;

  typedef struct {
    int hi;
    int lo;
    int gap;    // expected rising-edge spacing from previous bit, 0 = unchecked
    int bit_v;  // expected decoded bit, -1 = unchecked
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       bit_rdy_in;
  logic       bit_data_in;
  logic [7:0] t0h_cnt_in, t1h_cnt_in, tbit_cnt_in;
  logic       bit_done_out, busy_out, ovf_out, ws2812_dout;
  logic       inv_done, inv_busy, inv_ovf, inv_dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  ws2812_bit_enc #(.OUT_INV(1'b0)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bit_rdy_in(bit_rdy_in), .bit_data_in(bit_data_in),
    .t0h_cnt_in(t0h_cnt_in), .t1h_cnt_in(t1h_cnt_in), .tbit_cnt_in(tbit_cnt_in),
    .bit_done_out(bit_done_out), .busy_out(busy_out), .ovf_out(ovf_out), .ws2812_dout(ws2812_dout)
  );

  ws2812_bit_enc #(.OUT_INV(1'b1)) dut_inv (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bit_rdy_in(bit_rdy_in), .bit_data_in(bit_data_in),
    .t0h_cnt_in(t0h_cnt_in), .t1h_cnt_in(t1h_cnt_in), .tbit_cnt_in(tbit_cnt_in),
    .bit_done_out(inv_done), .busy_out(inv_busy), .ovf_out(inv_ovf), .ws2812_dout(inv_dout)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference timing straight from the pulse-width rules.
  function automatic exp_t model(input logic b, input int t0, input int t1, input int tb);
    exp_t e;
    int th, tl;
    th = b ? t1 : t0;
    if (th < 1) th = 1;
    tl = (tb > th) ? tb - th : 1;
    e.hi = th; e.lo = tl; e.gap = 0; e.bit_v = -1;
    return e;
  endfunction

  // Monitor: measures high/low lengths, bit_done position and edge spacing for both instances.
  int   in_bit[2], hi[2], lo[2], dn_n[2], dn_at[2], glitch[2], last_rise[2], rise_gap[2];
  logic bz[2], ln[2], dn[2];

  always @(negedge clk_in) begin
    exp_t e;
    bz[0] = busy_out; ln[0] = ws2812_dout;  dn[0] = bit_done_out;
    bz[1] = inv_busy; ln[1] = ~inv_dout;    dn[1] = inv_done;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n_in) begin
        in_bit[k] = 0;
      end else if (bz[k]) begin
        if (in_bit[k] == 0) begin
          in_bit[k] = 1; hi[k] = 0; lo[k] = 0; dn_n[k] = 0; dn_at[k] = 0; glitch[k] = 0;
          rise_gap[k] = cyc - last_rise[k];
          last_rise[k] = cyc;
        end
        if (ln[k]) begin
          if (lo[k] != 0) glitch[k]++;
          else hi[k]++;
        end else begin
          lo[k]++;
        end
        if (dn[k]) begin
          dn_n[k]++;
          dn_at[k] = lo[k];
        end
      end else if (in_bit[k] != 0) begin
        in_bit[k] = 0;
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
          total++; bad++;
          $display("FAIL unexpected_bit[%0d]: got a bit hi=%0d lo=%0d, expected none", k, hi[k], lo[k]);
        end else begin
          e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          chk($sformatf("high_len[%0d]", k), hi[k], e.hi);
          chk($sformatf("low_len[%0d]", k), lo[k], e.lo);
          chk($sformatf("done_count[%0d]", k), dn_n[k], 1);
          chk($sformatf("done_pos[%0d]", k), dn_at[k], e.lo);
          chk($sformatf("glitch[%0d]", k), glitch[k], 0);
          chk($sformatf("idle_line[%0d]", k), int'(ln[k]), 0);
          chk($sformatf("idle_done[%0d]", k), int'(dn[k]), 0);
          if (e.gap != 0) chk($sformatf("rise_gap[%0d]", k), rise_gap[k], e.gap);
          if (e.bit_v >= 0) chk($sformatf("decoded_bit[%0d]", k), (hi[k] >= 120) ? 1 : 0, e.bit_v);
        end
      end
    end
  end

  // Controller model: strobe, scramble inputs mid-bit, wait for bit_done, leave in the following idle cycle.
  task automatic send_bit(input logic b, input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] tb,
                          input int gap, input int dec, input int ovf_at, input bit rdy_on_done);
    exp_t e;
    int n;
    e = model(b, int'(t0), int'(t1), int'(tb));
    e.gap = gap; e.bit_v = dec;
    sb0.push_back(e); sb1.push_back(e);
    bit_data_in = b; t0h_cnt_in = t0; t1h_cnt_in = t1; tbit_cnt_in = tb; bit_rdy_in = 1'b1;
    @(posedge clk_in); #1;
    bit_rdy_in = 1'b0;
    n = 1;
    while (!bit_done_out && n < 700) begin
      bit_data_in = 1'($urandom); t0h_cnt_in = 8'($urandom);
      t1h_cnt_in = 8'($urandom); tbit_cnt_in = 8'($urandom);
      bit_rdy_in = (n == ovf_at);
      @(posedge clk_in); #1;
      n++;
    end
    bit_rdy_in = 1'b0;
    if (!bit_done_out) begin
      total++; bad++;
      $display("FAIL done_timeout: got no bit_done in %0d cycles, expected one", n);
    end else if (rdy_on_done) begin
      bit_rdy_in = 1'b1;
      bit_data_in = ~b;
    end
    @(posedge clk_in); #1;
    bit_rdy_in = 1'b0;
  endtask

  initial begin
    logic [23:0] pat;
    exp_t pe;
    int   gap, n;
    logic b;

    rst_n_in = 1'b1; bit_rdy_in = 1'b0; bit_data_in = 1'b0;
    t0h_cnt_in = 8'd80; t1h_cnt_in = 8'd160; tbit_cnt_in = 8'd249;
    #1 rst_n_in = 1'b0;
    #1;
    chk("rst_dout", int'(ws2812_dout), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(bit_done_out), 0);
    chk("rst_ovf", int'(ovf_out), 0);
    chk("rst_dout_inv", int'(inv_dout), 1);
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Nominal '1' then '0'.
    send_bit(1'b1, 8'd80, 8'd160, 8'd249, 0, 1, -1, 1'b0);
    send_bit(1'b0, 8'd80, 8'd160, 8'd249, 250, 0, -1, 1'b0);

    // 24-bit stream MSB first, back-to-back.
    pat = 24'hA5C33C;
    repeat (5) @(posedge clk_in);
    #1;
    gap = 0;
    for (int i = 0; i < 24; i++) begin
      b = pat[23 - i];
      send_bit(b, 8'd80, 8'd160, 8'd249, gap, int'(b), -1, 1'b0);
      gap = 250;
    end

    // Clamps: high longer than period, zero high time, equal high and period.
    send_bit(1'b1, 8'd80, 8'd200, 8'd150, 0, -1, -1, 1'b0);
    send_bit(1'b0, 8'd0, 8'd160, 8'd150, 0, -1, -1, 1'b0);
    send_bit(1'b0, 8'd0, 8'd0, 8'd0, 0, -1, -1, 1'b0);
    send_bit(1'b0, 8'd200, 8'd10, 8'd200, 0, -1, -1, 1'b0);
    send_bit(1'b1, 8'd0, 8'd255, 8'd255, 0, -1, -1, 1'b0);
    chk("ovf_clean", int'(ovf_out), 0);

    // Random timings, streamed with the period rule checked.
    pe.hi = 0; pe.lo = 0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] r0, r1, rb;
      exp_t m;
      b = 1'($urandom);
      r0 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      m = model(b, int'(r0), int'(r1), int'(rb));
      send_bit(b, r0, r1, rb, (i == 0) ? 0 : pe.hi + pe.lo + 1, -1, -1, 1'b0);
      pe = m;
    end

    // Strobe in HIGH cycle 10 is dropped and sets the sticky overflow.
    send_bit(1'b1, 8'd80, 8'd160, 8'd249, 0, 1, 10, 1'b0);
    chk("ovf_set", int'(ovf_out), 1);
    chk("ovf_set_inv", int'(inv_ovf), 1);
    send_bit(1'b0, 8'd80, 8'd160, 8'd249, 250, 0, -1, 1'b0);
    chk("ovf_sticky", int'(ovf_out), 1);

    // Reset mid-HIGH: line and busy return to idle at once.
    bit_data_in = 1'b1; bit_rdy_in = 1'b1;
    @(posedge clk_in); #1;
    bit_rdy_in = 1'b0;
    repeat (50) @(posedge clk_in);
    #1;
    chk("pre_rst_dout", int'(ws2812_dout), 1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_dout", int'(ws2812_dout), 0);
    chk("mid_rst_dout_inv", int'(inv_dout), 1);
    chk("mid_rst_busy", int'(busy_out), 0);
    chk("mid_rst_ovf", int'(ovf_out), 0);
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    send_bit(1'b1, 8'd80, 8'd160, 8'd249, 0, 1, -1, 1'b0);
    chk("post_rst_ovf", int'(ovf_out), 0);

    // Strobe coincident with bit_done is dropped and sets overflow.
    send_bit(1'b0, 8'd80, 8'd160, 8'd249, 250, 0, -1, 1'b1);
    chk("done_strobe_busy", int'(busy_out), 0);
    chk("done_strobe_ovf", int'(ovf_out), 1);

    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 100) begin
      @(posedge clk_in);
      n++;
    end
    repeat (5) @(posedge clk_in);
    chk("sb_drain", sb0.size() + sb1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
